sim_test_end_monitor: RTL and testbench
=======================================

Name: sim_test_end_monitor

Overview:
Parametrised simulation test-completion monitor for top-level benches. It watches NumSrc software test-status completion sources, an optional legacy GPIO magic-word signal, and a cycle-timeout watchdog. It captures the first terminating event, the pass/fail result and the cycle count at that event. It then holds a configurable drain window before pulsing finish_o, which the bench uses to call $finish; the block itself never calls $finish.

Parameters:
NumSrc, 4, number of independent completion sources (1..15)
DrainCycles, 7, cycles between event capture and finish_o pulse (0 allowed)
TimeoutCycles, 0, RUN cycles before a forced failing end; 0 disables the watchdog
GpioW, 32, legacy GPIO bus width
GpioMagic, 32'hDEADBEEF, legacy pass pattern (GpioW bits)
SrcW, $clog2(NumSrc+1), derived; width of src_id_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
done_i  in  NumSrc  per-source completion strobe, level-sampled each cycle
pass_i  in  NumSrc  per-source pass qualifier, sampled with the matching done_i bit
gpio_i  in  GpioW  legacy GPIO pin values (already masked by output enable)
gpio_chk_en_i  in  1  enables legacy magic-word detection
state_o  out  2  0=RUN, 1=DRAIN, 2=DONE
result_valid_o  out  1  an end event has been captured
pass_o  out  1  captured pass/fail
timeout_o  out  1  end was caused by the watchdog
src_id_o  out  SrcW  captured source: 0..NumSrc-1 for done_i, NumSrc for GPIO, 0 for timeout
cycle_count_o  out  32  cycle counter value in the event cycle
finish_o  out  1  single-cycle pulse at the end of drain
finished_o  out  1  sticky high from the finish_o cycle onward

Behaviour:
- Reset (rst_i=1 at a posedge): state RUN. All outputs 0. Internal cycle counter 0. Drain counter 0. Inputs are ignored while rst_i is high.
- Reset mid-DRAIN or in DONE: same as above. The finish_o pulse is cancelled. Captured results are cleared.
- cycle_cnt: 32-bit counter, 0 in the first cycle after reset. It increments by 1 each RUN cycle and saturates at 32'hFFFFFFFF without wrapping. It is frozen outside RUN.
- RUN event detection, priority highest first:
  - Lowest-index i with done_i[i]=1: pass=pass_i[i], src_id=i.
  - gpio_chk_en_i=1 and gpio_i==GpioMagic: pass=1, src_id=NumSrc.
  - TimeoutCycles!=0 and cycle_cnt==TimeoutCycles-1: pass=0, timeout=1, src_id=0.
- A real event and timeout in the same cycle: the real event wins and timeout_o stays 0.
- Event in cycle N:
  - At posedge ending N, the monitor captures the result.
  - From cycle N+1: result_valid_o=1; pass_o, timeout_o, src_id_o hold the captured values; cycle_count_o=cycle_cnt of cycle N.
- DrainCycles>0: state DRAIN from N+1 with drain counter loaded to 1. The counter increments each DRAIN cycle. When drain counter==DrainCycles, the block asserts finish_o for that one cycle and moves to DONE next cycle. The pulse therefore lands in cycle N+DrainCycles.
- DrainCycles=0: state goes RUN→DONE directly. finish_o is asserted in cycle N+1.
- finished_o rises in the same cycle as finish_o and stays high until reset.
- DRAIN/DONE: all further done_i/gpio/timeout activity is ignored, so captured values never change.
- done_i held high across many cycles causes exactly one capture.
- Captured outputs are stable in DONE indefinitely. finish_o pulses exactly once per reset.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- NumSrc=4, DrainCycles=7. done_i=4'b0100, pass_i=4'b0100 at cycle 20 → from cycle 21: result_valid_o=1, pass_o=1, src_id_o=2, cycle_count_o=20. finish_o high only in cycle 27; finished_o=1 from 27.
- Simultaneous done_i=4'b1010, pass_i=4'b1000 at cycle 5 → src_id_o=1, pass_o=0. A later done_i[0] pulse in DRAIN changes nothing.
- gpio_chk_en_i=1, gpio_i=32'hDEADBEEF at cycle 10, no done_i → src_id_o=4, pass_o=1, finish_o in cycle 17. The same stimulus with gpio_chk_en_i=0 gives no event.
- TimeoutCycles=100, no activity → event at cycle 99: timeout_o=1, pass_o=0, cycle_count_o=99, finish_o in cycle 106. A second run with done_i[3] also at cycle 99 → timeout_o=0, src_id_o=3.
- DrainCycles=0: done_i[0] at cycle 3 → finish_o in cycle 4, state_o=2 from cycle 4.
- rst_i asserted in cycle 24 during DRAIN of the first test → no finish_o. All outputs 0 from cycle 25. The counter restarts, and a new event at cycle 30 is captured with cycle_count_o=5.

Source files
------------

// File: rtl/sim_test_end_monitor.sv
// Test-completion monitor: captures the first done/GPIO/watchdog end event, then pulses finish_o after a drain window.
// Latency: captured results are visible one cycle after the event; no backpressure, inputs are sampled every RUN cycle.
module sim_test_end_monitor #(
    parameter int unsigned       NumSrc        = 4,
    parameter int unsigned       DrainCycles   = 7,
    parameter int unsigned       TimeoutCycles = 0,
    parameter int unsigned       GpioW         = 32,
    parameter logic [GpioW-1:0]  GpioMagic     = GpioW'(32'hDEADBEEF),
    parameter int unsigned       SrcW          = $clog2(NumSrc + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumSrc-1:0] done_i,
    input  logic [NumSrc-1:0] pass_i,
    input  logic [GpioW-1:0]  gpio_i,
    input  logic              gpio_chk_en_i,
    output logic [1:0]        state_o,
    output logic              result_valid_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [SrcW-1:0]   src_id_o,
    output logic [31:0]       cycle_count_o,
    output logic              finish_o,
    output logic              finished_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [31:0] DrainLast   = 32'(DrainCycles);
    localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles) - 32'd1;
    localparam bit          TimeoutEn   = (TimeoutCycles != 0);

    state_e            state_q, state_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic [31:0]       drain_cnt_q, drain_cnt_d;
    logic              vld_q, vld_d;
    logic              pass_q, pass_d;
    logic              to_q, to_d;
    logic [SrcW-1:0]   src_q, src_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              finish_q, finish_d;
    logic              finished_q, finished_d;

    logic              ev_hit;
    logic              ev_pass;
    logic              ev_to;
    logic [SrcW-1:0]   ev_src;

    // Descending scan so the lowest-index asserted source is the last writer.
    always_comb begin
        ev_hit  = 1'b0;
        ev_pass = 1'b0;
        ev_to   = 1'b0;
        ev_src  = '0;
        for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
            if (done_i[i]) begin
                ev_hit  = 1'b1;
                ev_pass = pass_i[i];
                ev_src  = SrcW'(i);
            end
        end
        if (!ev_hit && gpio_chk_en_i && (gpio_i == GpioMagic)) begin
            ev_hit  = 1'b1;
            ev_pass = 1'b1;
            ev_src  = SrcW'(NumSrc);
        end
        if (!ev_hit && TimeoutEn && (cycle_cnt_q == TimeoutLast)) begin
            ev_hit = 1'b1;
            ev_to  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        drain_cnt_d = drain_cnt_q;
        vld_d       = vld_q;
        pass_d      = pass_q;
        to_d        = to_q;
        src_d       = src_q;
        cnt_d       = cnt_q;
        finish_d    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (cycle_cnt_q != 32'hFFFF_FFFF) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
                if (ev_hit) begin
                    vld_d  = 1'b1;
                    pass_d = ev_pass;
                    to_d   = ev_to;
                    src_d  = ev_src;
                    cnt_d  = cycle_cnt_q;
                    if (DrainCycles == 0) begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = 32'd1;
                        finish_d    = (DrainLast == 32'd1);
                    end
                end
            end
            ST_DRAIN: begin
                // finish_q is already high in the cycle drain_cnt_q reaches DrainLast.
                if (drain_cnt_q == DrainLast) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 32'd1;
                    finish_d    = (drain_cnt_d == DrainLast);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        finished_d = finished_q | finish_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            cycle_cnt_q <= '0;
            drain_cnt_q <= '0;
            vld_q       <= 1'b0;
            pass_q      <= 1'b0;
            to_q        <= 1'b0;
            src_q       <= '0;
            cnt_q       <= '0;
            finish_q    <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            vld_q       <= vld_d;
            pass_q      <= pass_d;
            to_q        <= to_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            finish_q    <= finish_d;
            finished_q  <= finished_d;
        end
    end

    assign state_o        = state_q;
    assign result_valid_o = vld_q;
    assign pass_o         = pass_q;
    assign timeout_o      = to_q;
    assign src_id_o       = src_q;
    assign cycle_count_o  = cnt_q;
    assign finish_o       = finish_q;
    assign finished_o     = finished_q;

endmodule

// File: tb/tb_sim_test_end_monitor.sv
// Bench for sim_test_end_monitor: three parameterisations share one stimulus bus and are checked every cycle.
module tb_sim_test_end_monitor;

    localparam logic [31:0] MAGIC = 32'hDEADBEEF;

    typedef struct packed {
        logic [1:0]  st;
        logic        vld;
        logic        pas;
        logic        to;
        logic [3:0]  src;
        logic [31:0] cnt;
        logic        fin;
        logic        fnd;
    } obs_t;

    typedef struct {
        string       name;
        int          dut;
        logic [3:0]  done;
        logic [3:0]  pass;
        bit          gen;
        logic [31:0] gpio;
        int          at;
        int          e;
        int          src;
        bit          p;
        bit          to;
        int          last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  done;
    logic [3:0]  pass;
    logic [31:0] gpio;
    logic        gen;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // dut 0: NumSrc=4 Drain=7 Timeout=100 ; dut 1: NumSrc=4 Drain=0 ; dut 2: NumSrc=3 Drain=2 Timeout=40
    logic [1:0]  st_a, st_b, st_c;
    logic        vld_a, vld_b, vld_c, pas_a, pas_b, pas_c, to_a, to_b, to_c;
    logic [2:0]  src_a, src_b;
    logic [1:0]  src_c;
    logic [31:0] cnt_a, cnt_b, cnt_c;
    logic        fin_a, fin_b, fin_c, fnd_a, fnd_b, fnd_c;
    obs_t        obs_a, obs_b, obs_c;

    sim_test_end_monitor #(.NumSrc(4), .DrainCycles(7), .TimeoutCycles(100)) dut_a (
        .clk_i(clk), .rst_i(rst), .done_i(done), .pass_i(pass), .gpio_i(gpio), .gpio_chk_en_i(gen),
        .state_o(st_a), .result_valid_o(vld_a), .pass_o(pas_a), .timeout_o(to_a), .src_id_o(src_a),
        .cycle_count_o(cnt_a), .finish_o(fin_a), .finished_o(fnd_a));

    sim_test_end_monitor #(.NumSrc(4), .DrainCycles(0), .TimeoutCycles(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .done_i(done), .pass_i(pass), .gpio_i(gpio), .gpio_chk_en_i(gen),
        .state_o(st_b), .result_valid_o(vld_b), .pass_o(pas_b), .timeout_o(to_b), .src_id_o(src_b),
        .cycle_count_o(cnt_b), .finish_o(fin_b), .finished_o(fnd_b));

    sim_test_end_monitor #(.NumSrc(3), .DrainCycles(2), .TimeoutCycles(40)) dut_c (
        .clk_i(clk), .rst_i(rst), .done_i(done[2:0]), .pass_i(pass[2:0]), .gpio_i(gpio), .gpio_chk_en_i(gen),
        .state_o(st_c), .result_valid_o(vld_c), .pass_o(pas_c), .timeout_o(to_c), .src_id_o(src_c),
        .cycle_count_o(cnt_c), .finish_o(fin_c), .finished_o(fnd_c));

    assign obs_a = {st_a, vld_a, pas_a, to_a, 1'b0, src_a, cnt_a, fin_a, fnd_a};
    assign obs_b = {st_b, vld_b, pas_b, to_b, 1'b0, src_b, cnt_b, fin_b, fnd_b};
    assign obs_c = {st_c, vld_c, pas_c, to_c, 2'b00, src_c, cnt_c, fin_c, fnd_c};

    function automatic obs_t sel(int d);
        case (d)
            0:       return obs_a;
            1:       return obs_b;
            default: return obs_c;
        endcase
    endfunction

    function automatic int drain_of(int d);
        return (d == 0) ? 7 : (d == 1) ? 0 : 2;
    endfunction

    function automatic int nsrc_of(int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int timeout_of(int d);
        return (d == 0) ? 100 : (d == 1) ? 0 : 40;
    endfunction

    // Expected outputs in cycle c given an event captured in cycle e (ev=0: nothing captured yet).
    function automatic obs_t expect_obs(int c, bit ev, int e, int src, bit p, bit to, int d);
        obs_t o;
        int   fc;
        o = '0;
        if (ev && c > e) begin
            fc    = e + ((d == 0) ? 1 : d);
            o.vld = 1'b1;
            o.pas = p;
            o.to  = to;
            o.src = 4'(src);
            o.cnt = 32'(e);
            o.st  = (c >= e + d + 1) ? 2'd2 : 2'd1;
            o.fin = (c == fc);
            o.fnd = (c >= fc);
        end
        return o;
    endfunction

    task automatic check(string name, int c, obs_t got, obs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h (st,vld,pass,to,src,cnt,fin,fnd)", name, c, got, want);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drive(logic [3:0] dn, logic [3:0] ps, bit g, logic [31:0] gp);
        done = dn;
        pass = ps;
        gen  = g;
        gpio = gp;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];

    bit   mev[3];
    int   me[3], msrc[3];
    bit   mp[3], mto[3];

    initial begin
        int nfin;
        int c;

        rst = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 32'd0);

        tbl[0] = '{"src2_pass",      0, 4'b0100, 4'b0100, 1'b0, 32'd0, 20, 20, 2, 1'b1, 1'b0, 32};
        tbl[1] = '{"simul_1010",     0, 4'b1010, 4'b1000, 1'b0, 32'd0,  5,  5, 1, 1'b0, 1'b0, 16};
        tbl[2] = '{"gpio_magic",     0, 4'b0000, 4'b0000, 1'b1, MAGIC, 10, 10, 4, 1'b1, 1'b0, 22};
        tbl[3] = '{"timeout",        0, 4'b0000, 4'b0000, 1'b0, 32'd0, -1, 99, 0, 1'b0, 1'b1, 110};
        tbl[4] = '{"done3_vs_to",    0, 4'b1000, 4'b0000, 1'b0, 32'd0, 99, 99, 3, 1'b0, 1'b0, 110};
        tbl[5] = '{"done_beats_gpio",0, 4'b0001, 4'b0001, 1'b1, MAGIC,  8,  8, 0, 1'b1, 1'b0, 20};
        tbl[6] = '{"drain0",         1, 4'b0001, 4'b0001, 1'b0, 32'd0,  3,  3, 0, 1'b1, 1'b0, 10};
        tbl[7] = '{"gpio_vs_to",     0, 4'b0000, 4'b0000, 1'b1, MAGIC, 99, 99, 4, 1'b1, 1'b0, 110};

        foreach (tbl[k]) begin
            do_reset();
            for (int cy = 0; cy <= tbl[k].last; cy++) begin
                if (cy == tbl[k].at) drive(tbl[k].done, tbl[k].pass, tbl[k].gen, tbl[k].gpio);
                else                 drive(4'd0, 4'd0, 1'b0, 32'd0);
                @(negedge clk);
                check(tbl[k].name, cy, sel(tbl[k].dut),
                      expect_obs(cy, 1'b1, tbl[k].e, tbl[k].src, tbl[k].p, tbl[k].to, drain_of(tbl[k].dut)));
                next_cycle();
            end
        end

        // Magic word with detection disabled never ends the test.
        do_reset();
        for (int cy = 0; cy <= 40; cy++) begin
            drive(4'd0, 4'd0, 1'b0, (cy >= 10) ? MAGIC : 32'd0);
            @(negedge clk);
            check("gpio_disabled", cy, obs_a, expect_obs(cy, 1'b0, 0, 0, 1'b0, 1'b0, 7));
            next_cycle();
        end

        // done held high for many cycles plus stray events in DRAIN: single capture, single pulse.
        do_reset();
        nfin = 0;
        for (int cy = 0; cy <= 30; cy++) begin
            drive((cy >= 2 && cy <= 15) ? 4'b0010 : 4'b0000, 4'b0010, 1'b0, 32'd0);
            if (cy == 6 || cy == 20) drive(done | 4'b0001, 4'b0011, 1'b1, MAGIC);
            @(negedge clk);
            if (fin_a) nfin++;
            check("held_done", cy, obs_a, expect_obs(cy, 1'b1, 2, 1, 1'b1, 1'b0, 7));
            next_cycle();
        end
        check_int("held_done_pulses", nfin, 1);

        // Reset in cycle 24 of a drain cancels the pulse; the counter restarts for the next event.
        do_reset();
        nfin = 0;
        for (int cy = 0; cy <= 24; cy++) begin
            drive((cy == 20) ? 4'b0100 : 4'b0000, 4'b0100, 1'b0, 32'd0);
            rst = (cy == 24);
            @(negedge clk);
            if (fin_a) nfin++;
            check("pre_reset", cy, obs_a, expect_obs(cy, 1'b1, 20, 2, 1'b1, 1'b0, 7));
            next_cycle();
        end
        rst = 1'b0;
        check_int("pre_reset_pulses", nfin, 0);
        for (int cy = 0; cy <= 15; cy++) begin
            drive((cy == 5) ? 4'b0100 : 4'b0000, 4'b0000, 1'b0, 32'd0);
            @(negedge clk);
            check("post_reset", cy, obs_a, expect_obs(cy, 1'b1, 5, 2, 1'b0, 1'b0, 7));
            next_cycle();
        end

        // Randomised run against the reference model on all three instances.
        for (int ep = 0; ep < 12; ep++) begin
            int len;
            do_reset();
            c   = 0;
            for (int d = 0; d < 3; d++) mev[d] = 1'b0;
            len = $urandom_range(60, 160);
            for (int k = 0; k < len; k++) begin
                rst  = ($urandom_range(0, 99) == 0);
                done = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'd0;
                pass = 4'($urandom);
                gen  = 1'($urandom_range(0, 1));
                gpio = ($urandom_range(0, 19) == 0) ? MAGIC : 32'($urandom);
                @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    check("random", c, sel(d), expect_obs(c, mev[d], me[d], msrc[d], mp[d], mto[d], drain_of(d)));
                end
                if (rst) begin
                    for (int d = 0; d < 3; d++) mev[d] = 1'b0;
                    c = 0;
                end else begin
                    for (int d = 0; d < 3; d++) begin
                        if (!mev[d]) begin
                            for (int i = 0; i < nsrc_of(d); i++) begin
                                if (!mev[d] && done[i]) begin
                                    mev[d] = 1'b1; me[d] = c; msrc[d] = i; mp[d] = pass[i]; mto[d] = 1'b0;
                                end
                            end
                            if (!mev[d] && gen && gpio == MAGIC) begin
                                mev[d] = 1'b1; me[d] = c; msrc[d] = nsrc_of(d); mp[d] = 1'b1; mto[d] = 1'b0;
                            end
                            if (!mev[d] && timeout_of(d) != 0 && c == timeout_of(d) - 1) begin
                                mev[d] = 1'b1; me[d] = c; msrc[d] = 0; mp[d] = 1'b0; mto[d] = 1'b1;
                            end
                        end
                    end
                    c++;
                end
                next_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
